// File: rtl/bp_pkg.sv
// bp_pkg: shared 2-bit counter constants, saturating update and BTB entry type for the branch predictor.
package bp_pkg;

    localparam int BP_XLEN_MAX = 32;

    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    typedef struct packed {
        logic                   valid;
        logic [BP_XLEN_MAX-1:0] tag;
        logic [BP_XLEN_MAX-1:0] target;
        logic                   cond;
    } btb_entry_t;

    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        return taken ? (cnt == ST ? ST : cnt + 2'd1) : (cnt == SNT ? SNT : cnt - 2'd1);
    endfunction

endpackage

// File: rtl/bp_pht.sv
// bp_pht: untagged table of 2-bit saturating direction counters, one read and one update port.
module bp_pht
    import bp_pkg::*;
#(
    parameter int GHR_BITS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [GHR_BITS-1:0] rd_idx,
    output logic                rd_taken,
    input  logic                wr_en,
    input  logic [GHR_BITS-1:0] wr_idx,
    input  logic                wr_taken
);

    logic [1:0] cnt [2**GHR_BITS];

    assign rd_taken = cnt[rd_idx] >= WT;

    always_ff @(posedge clk) begin
        if (!reset)
            for (int i = 0; i < 2**GHR_BITS; i++) cnt[i] <= WNT;
        else if (wr_en)
            cnt[wr_idx] <= sat_update(cnt[wr_idx], wr_taken);
    end

endmodule

// File: rtl/gshare_branch_predictor.sv
// gshare_branch_predictor: BTB + gshare PHT next-PC predictor with speculative GHR and mispredict repair.
// Define BP_STATS_EN to add the stat_lookups / stat_mispredicts counters.
module gshare_branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 32,
    parameter int GHR_BITS    = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                lookup_en,
    input  logic [XLEN-1:0]     if_pc,
    output logic                pred_taken,
    output logic [XLEN-1:0]     pred_next_pc,
    output logic [GHR_BITS-1:0] pred_ghr,
    input  logic                upd_valid,
    input  logic [XLEN-1:0]     upd_pc,
    input  logic                upd_is_cond,
    input  logic                upd_taken,
    input  logic [XLEN-1:0]     upd_target,
    input  logic [GHR_BITS-1:0] upd_ghr,
`ifdef BP_STATS_EN
    output logic [31:0]         stat_lookups,
    output logic [31:0]         stat_mispredicts,
`endif
    input  logic                upd_mispredict
);

    localparam int BTB_IDX = $clog2(BTB_ENTRIES);

    btb_entry_t           btb [BTB_ENTRIES];
    btb_entry_t           lk_entry;
    logic [BTB_IDX-1:0]   lk_idx;
    logic [BTB_IDX-1:0]   wr_idx;
    logic [GHR_BITS-1:0]  ghr;
    logic                 hit;
    logic                 pht_taken;
    logic                 spec_shift;
    logic                 repair;
    logic                 unused_pc_bits;

    assign lk_idx     = if_pc[BTB_IDX+1:2];
    assign wr_idx     = upd_pc[BTB_IDX+1:2];
    assign lk_entry   = btb[lk_idx];
    assign hit        = lk_entry.valid && lk_entry.tag == BP_XLEN_MAX'(if_pc[XLEN-1:BTB_IDX+2]);
    assign pred_taken = hit && (!lk_entry.cond || pht_taken);
    assign pred_ghr   = ghr;
    assign spec_shift = lookup_en && hit && lk_entry.cond;
    assign repair     = upd_valid && upd_mispredict;
    assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

    always_comb pred_next_pc = pred_taken ? lk_entry.target[XLEN-1:0] : if_pc + XLEN'(4);

    bp_pht #(.GHR_BITS(GHR_BITS)) u_pht (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (if_pc[GHR_BITS+1:2] ^ ghr),
        .rd_taken (pht_taken),
        .wr_en    (upd_valid && upd_is_cond),
        .wr_idx   (upd_pc[GHR_BITS+1:2] ^ upd_ghr),
        .wr_taken (upd_taken)
    );

    // Only taken outcomes allocate; tag and target need no reset since valid guards them.
    always_ff @(posedge clk) begin
        if (!reset)
            for (int i = 0; i < BTB_ENTRIES; i++) btb[i].valid <= 1'b0;
        else if (upd_valid && upd_taken)
            btb[wr_idx] <= '{valid:  1'b1,
                             tag:    BP_XLEN_MAX'(upd_pc[XLEN-1:BTB_IDX+2]),
                             target: BP_XLEN_MAX'(upd_target),
                             cond:   upd_is_cond};
    end

    // Repair from the EX snapshot wins over this cycle's speculative shift.
    always_ff @(posedge clk) begin
        if (!reset)
            ghr <= '0;
        else if (repair)
            ghr <= upd_is_cond ? {upd_ghr[GHR_BITS-2:0], upd_taken} : upd_ghr;
        else if (spec_shift)
            ghr <= {ghr[GHR_BITS-2:0], pred_taken};
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_lookups     <= '0;
            stat_mispredicts <= '0;
        end else begin
            stat_lookups     <= stat_lookups + 32'(spec_shift);
            stat_mispredicts <= stat_mispredicts + 32'(repair);
        end
    end
`endif

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// tb_gshare_branch_predictor: directed scenarios plus randomized traffic checked against an array-based model.
module tb_gshare_branch_predictor;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        lookup_en = 1'b0;
    logic [31:0] if_pc = '0;
    logic        pred_taken;
    logic [31:0] pred_next_pc;
    logic [4:0]  pred_ghr;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_is_cond = 1'b0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic [4:0]  upd_ghr = '0;
    logic        upd_mispredict = 1'b0;
`ifdef BP_STATS_EN
    logic [31:0] stat_lookups, stat_mispredicts;
    int unsigned m_lk, m_mp;
`endif

    int n_checks = 0;
    int n_fail = 0;

    bit          m_valid [32];
    int unsigned m_tag [32];
    int unsigned m_tgt [32];
    bit          m_cond [32];
    int          m_pht [32];
    int          m_ghr;

    gshare_branch_predictor dut (
        .clk            (clk),
        .reset          (reset),
        .lookup_en      (lookup_en),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_next_pc   (pred_next_pc),
        .pred_ghr       (pred_ghr),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_is_cond    (upd_is_cond),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_ghr        (upd_ghr),
`ifdef BP_STATS_EN
        .stat_lookups     (stat_lookups),
        .stat_mispredicts (stat_mispredicts),
`endif
        .upd_mispredict (upd_mispredict)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic bit m_hit(input logic [31:0] pc);
        int i = int'((pc >> 2) % 32);
        return m_valid[i] && m_tag[i] == (pc >> 7);
    endfunction

    function automatic bit m_taken(input logic [31:0] pc);
        int i = int'((pc >> 2) % 32);
        return m_hit(pc) && (!m_cond[i] || m_pht[i ^ m_ghr] >= 2);
    endfunction

    function automatic logic [31:0] m_next(input logic [31:0] pc);
        return m_taken(pc) ? m_tgt[int'((pc >> 2) % 32)] : pc + 32'd4;
    endfunction

    task automatic m_edge();
        int li, ui, pi;
        bit spec, spec_t;
        li = int'((if_pc >> 2) % 32);
        spec = lookup_en && m_hit(if_pc) && m_cond[li];
        spec_t = m_taken(if_pc);
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                m_valid[i] = 0;
                m_pht[i] = 1;
            end
            m_ghr = 0;
`ifdef BP_STATS_EN
            m_lk = 0;
            m_mp = 0;
`endif
            return;
        end
        ui = int'((upd_pc >> 2) % 32);
        if (upd_valid && upd_is_cond) begin
            pi = ui ^ int'(upd_ghr);
            m_pht[pi] = upd_taken ? (m_pht[pi] == 3 ? 3 : m_pht[pi] + 1) : (m_pht[pi] == 0 ? 0 : m_pht[pi] - 1);
        end
        if (upd_valid && upd_taken) begin
            m_valid[ui] = 1;
            m_tag[ui] = upd_pc >> 7;
            m_tgt[ui] = upd_target;
            m_cond[ui] = upd_is_cond;
        end
`ifdef BP_STATS_EN
        m_lk += spec;
        m_mp += (upd_valid && upd_mispredict);
`endif
        if (upd_valid && upd_mispredict)
            m_ghr = upd_is_cond ? (int'(upd_ghr) * 2 + int'(upd_taken)) % 32 : int'(upd_ghr);
        else if (spec)
            m_ghr = (m_ghr * 2 + int'(spec_t)) % 32;
    endtask

    task automatic tick();
        m_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input logic v, input logic [31:0] pc, input logic c, input logic t,
                           input logic [31:0] tgt, input logic [4:0] g, input logic mp);
        upd_valid = v;
        upd_pc = pc;
        upd_is_cond = c;
        upd_taken = t;
        upd_target = tgt;
        upd_ghr = g;
        upd_mispredict = mp;
    endtask

    function automatic logic [31:0] rand_pc();
        return ($urandom_range(0, 9) == 0) ? ($urandom & 32'hFFFF_FFFC)
                                          : (($urandom_range(0, 3) << 7) | ($urandom_range(0, 31) << 2));
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        if_pc = 32'h100;
        lookup_en = 1'b0;
        #1;
        n_checks++;
        if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_taken: got %b want 0", pred_taken); end
        n_checks++;
        if (pred_next_pc !== 32'h104) begin n_fail++; $display("FAIL reset_next_pc: got %h want 00000104", pred_next_pc); end
        n_checks++;
        if (pred_ghr !== 5'd0) begin n_fail++; $display("FAIL reset_ghr: got %b want 00000", pred_ghr); end
`ifdef BP_STATS_EN
        n_checks++;
        if (stat_lookups !== 32'd0 || stat_mispredicts !== 32'd0) begin
            n_fail++; $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_lookups, stat_mispredicts);
        end
`endif
    endtask

    task automatic test_btb_alloc();
        set_upd(1, 32'h40, 1, 1, 32'h80, 5'd0, 0);
        tick();
        set_upd(0, 0, 0, 0, 0, 0, 0);
        if_pc = 32'h40;
        #1;
        n_checks++;
        if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL alloc_taken: got %b want 1", pred_taken); end
        n_checks++;
        if (pred_next_pc !== 32'h80) begin n_fail++; $display("FAIL alloc_next_pc: got %h want 00000080", pred_next_pc); end
    endtask

    task automatic test_saturation();
        repeat (4) begin
            set_upd(1, 32'h40, 1, 1, 32'h80, 5'd0, 0);
            tick();
        end
        set_upd(1, 32'h40, 1, 0, 32'h0, 5'd0, 0);
        tick();
        set_upd(0, 0, 0, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (pred_next_pc !== 32'h80) begin n_fail++; $display("FAIL sat_one_nt: got %h want 00000080", pred_next_pc); end
        set_upd(1, 32'h40, 1, 0, 32'h0, 5'd0, 0);
        tick();
        set_upd(0, 0, 0, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (pred_next_pc !== 32'h44 || pred_taken !== 1'b0) begin
            n_fail++; $display("FAIL sat_two_nt: got %h/%b want 00000044/0", pred_next_pc, pred_taken);
        end
    endtask

    task automatic test_jal();
        set_upd(1, 32'h200, 0, 1, 32'h300, 5'd0, 0);
        tick();
        set_upd(0, 0, 0, 0, 0, 0, 0);
        if_pc = 32'h200;
        lookup_en = 1'b1;
        #1;
        n_checks++;
        if (pred_taken !== 1'b1 || pred_next_pc !== 32'h300) begin
            n_fail++; $display("FAIL jal_lookup: got %b/%h want 1/00000300", pred_taken, pred_next_pc);
        end
        tick();
        lookup_en = 1'b0;
        n_checks++;
        if (pred_ghr !== 5'd0) begin n_fail++; $display("FAIL jal_ghr: got %b want 00000", pred_ghr); end
    endtask

    task automatic test_ghr_repair();
        set_upd(1, 32'h40, 1, 1, 32'h80, 5'd0, 0);
        tick();
        set_upd(1, 32'h40, 1, 1, 32'h80, 5'd1, 0);
        tick();
        set_upd(1, 32'h40, 1, 1, 32'h80, 5'd3, 0);
        tick();
        set_upd(0, 0, 0, 0, 0, 0, 0);
        if_pc = 32'h40;
        lookup_en = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (pred_ghr !== 5'b00111) begin n_fail++; $display("FAIL ghr_spec: got %b want 00111", pred_ghr); end
        set_upd(1, 32'h40, 1, 0, 32'h0, 5'b00001, 1);
        tick();
        lookup_en = 1'b0;
        set_upd(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (pred_ghr !== 5'b00010) begin n_fail++; $display("FAIL ghr_repair: got %b want 00010", pred_ghr); end
    endtask

    task automatic test_tag_conflict();
        if_pc = 32'hC0;
        #1;
        n_checks++;
        if (pred_taken !== 1'b0 || pred_next_pc !== 32'hC4) begin
            n_fail++; $display("FAIL tag_conflict: got %b/%h want 0/000000c4", pred_taken, pred_next_pc);
        end
    endtask

    task automatic test_boundaries();
        set_upd(0, 32'h40, 1, 1, 32'h0, 5'h1F, 1);
        tick();
        set_upd(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (pred_ghr !== 5'b00010) begin n_fail++; $display("FAIL ignored_mispredict: got %b want 00010", pred_ghr); end
        if_pc = 32'hFFFF_FFFC;
        #1;
        n_checks++;
        if (pred_next_pc !== 32'h0) begin n_fail++; $display("FAIL pc_wrap: got %h want 00000000", pred_next_pc); end
        if_pc = 32'h500;
        set_upd(1, 32'h500, 0, 1, 32'h600, 5'd0, 0);
        #1;
        n_checks++;
        if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL same_cycle_no_bypass: got %b want 0", pred_taken); end
        tick();
        set_upd(1, 32'h700, 1, 0, 32'h900, 5'd0, 0);
        n_checks++;
        if (pred_next_pc !== 32'h600) begin n_fail++; $display("FAIL same_cycle_write: got %h want 00000600", pred_next_pc); end
        tick();
        set_upd(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (pred_next_pc !== 32'h600) begin n_fail++; $display("FAIL nt_no_evict: got %h want 00000600", pred_next_pc); end
        reset = 1'b0;
        set_upd(1, 32'h800, 0, 1, 32'h900, 5'd0, 1);
        tick();
        reset = 1'b1;
        set_upd(0, 0, 0, 0, 0, 0, 0);
        if_pc = 32'h800;
        #1;
        n_checks++;
        if (pred_taken !== 1'b0 || pred_next_pc !== 32'h804 || pred_ghr !== 5'd0) begin
            n_fail++; $display("FAIL midop_reset: got %b/%h/%b want 0/00000804/00000", pred_taken, pred_next_pc, pred_ghr);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 149) != 0);
            lookup_en = 1'($urandom_range(0, 1));
            if_pc = rand_pc();
            upd_valid = 1'($urandom_range(0, 1));
            upd_pc = rand_pc();
            upd_is_cond = ($urandom_range(0, 3) != 0);
            upd_taken = upd_is_cond ? 1'($urandom_range(0, 1)) : 1'b1;
            upd_target = $urandom & 32'hFFFF_FFFC;
            upd_ghr = 5'($urandom);
            upd_mispredict = ($urandom_range(0, 3) == 0);
            #1;
            n_checks++;
            if (pred_taken !== m_taken(if_pc)) begin
                n_fail++; $display("FAIL rand_taken pc=%h: got %b want %b", if_pc, pred_taken, m_taken(if_pc));
            end
            n_checks++;
            if (pred_next_pc !== m_next(if_pc)) begin
                n_fail++; $display("FAIL rand_next_pc pc=%h: got %h want %h", if_pc, pred_next_pc, m_next(if_pc));
            end
            n_checks++;
            if (pred_ghr !== 5'(m_ghr)) begin
                n_fail++; $display("FAIL rand_ghr: got %b want %b", pred_ghr, 5'(m_ghr));
            end
            tick();
        end
        reset = 1'b1;
        set_upd(0, 0, 0, 0, 0, 0, 0);
        lookup_en = 1'b0;
`ifdef BP_STATS_EN
        n_checks++;
        if (stat_lookups !== m_lk || stat_mispredicts !== m_mp) begin
            n_fail++; $display("FAIL stats: got %0d/%0d want %0d/%0d", stat_lookups, stat_mispredicts, m_lk, m_mp);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_btb_alloc();
        test_saturation();
        test_jal();
        test_ghr_repair();
        test_tag_conflict();
        test_boundaries();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
